id_ex_alu_issue: RTL
====================

// Module: id_ex_alu_issue
// PURPOSE
//  Decode/issue stage feeding the 32-bit ALU of the pipelined MIPS core. Decodes
//  opcode/funct into the 4-bit ALU control code, selects and forwards operands,
//  and registers everything into the ID/EX pipeline register driving the ALU
//  inputs (input1, input2, ALUControl, shamt). It is the producer side of the
//  ALU interface.
// PARAMETERS
//  DW        32   datapath width
//  RW        5    register index width
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  id_valid     in   1   decoded instruction present in ID
//  opcode       in   6   instr[31:26]
//  funct        in   6   instr[5:0]
//  shamt_in     in   5   instr[10:6]
//  rt_idx       in   RW  instr[20:16]
//  rd_idx       in   RW  instr[15:11]
//  imm16        in   16  instr[15:0]
//  rs_data      in   DW  register-file read port A
//  rt_data      in   DW  register-file read port B
//  fwd_a_sel    in   2   00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 = 00
//  fwd_b_sel    in   2   same encoding, for the rt operand
//  exmem_res    in   DW  EX/MEM forwarded value
//  memwb_res    in   DW  MEM/WB forwarded value
//  stall        in   1   hold ID/EX contents
//  flush        in   1   replace ID/EX contents with a bubble
//  ex_valid     out  1   ID/EX slot holds a real instruction
//  alu_ctrl     out  4   ALU control code
//  alu_in1      out  DW  ALU input1
//  alu_in2      out  DW  ALU input2
//  alu_shamt    out  5   ALU shift amount
//  ovf_en       out  1   trap on ALU overFlow (signed add/sub/addi only)
//  wr_en        out  1   write the result to the register file
//  wr_idx       out  RW  destination register
//  is_branch    out  1   beq/bne; the next stage uses the ALU zero output
//  illegal      out  1   unrecognised opcode/funct
// BEHAVIOUR
//  - ALU control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SRL 0101,
//    SRA 0110, GREATER 0111, LESSER 1000, NOR 1001.
//  - R-type decode (opcode 0x00), by funct:
//    - 20/21 ADD; 22/23 SUB; ovf_en=1 only for 20 and 22.
//    - 24 AND; 25 OR; 27 NOR; 2A LESSER.
//    - 00 SLL, 02 SRL, 03 SRA: alu_in1 = forwarded rt value, alu_shamt = shamt_in.
//    - All R-type: wr_idx = rd_idx, wr_en = 1.
//  - I-type decode, wr_idx = rt_idx:
//    - 08 addi: ADD, sign-extended imm, ovf_en = 1.
//    - 09 addiu: ADD, sign-extended imm.
//    - 0A slti: LESSER, sign-extended imm.
//    - 0C andi: AND, zero-extended imm.
//    - 0D ori: OR, zero-extended imm.
//    - 23 lw: ADD, sign-extended imm, wr_en = 1.
//    - 2B sw: ADD, sign-extended imm, wr_en = 0.
//    - 04 beq, 05 bne: SUB on rs/rt, is_branch = 1, wr_en = 0.
//  - Operand routing: non-shift ops use alu_in1 = forwarded rs value. alu_in2 =
//    forwarded rt value (R-type, branch) or the extended immediate.
//    alu_shamt = 0 for every non-shift op.
//  - Illegal opcode or funct: issued with ex_valid = 1, illegal = 1, alu_ctrl = ADD,
//    wr_en = 0, ovf_en = 0.
//  - Latency: one cycle, ID inputs to registered outputs. All outputs are flops; no
//    combinational path from input to output.
//  - Update priority each clock edge: flush > stall > load.
//    - flush: bubble — every output 0 (alu_ctrl = ADD).
//    - stall (no flush): every output holds.
//    - otherwise: load the decode of the inputs; if id_valid = 0, load a bubble.
//  - Reset: asynchronous; every output goes to 0 (bubble) immediately.
//    Deassertion takes effect at the next clock edge.
//  - A bubble never asserts wr_en, ovf_en, is_branch or illegal.
// STRUCTURE
//  - Shared package mips_alu_pkg: ALU control codes, opcode/funct constants,
//    forwarding-select encoding. The ALU is refactored to use the same package.
//  - One sub-module, alu_ctrl_decode: combinational opcode/funct decoder giving
//    alu_ctrl, ovf_en, wr_en, dst_is_rd, imm_sext, is_shift, is_branch, illegal.
//  - The top level holds the forwarding muxes, immediate extension and the ID/EX
//    register.
// TESTING
//  1. reset=1 mid-stream with valid data -> all outputs 0 with no clock edge;
//     first edge after release loads a fresh decode.
//  2. add $3,$1,$2, rs=7, rt=-3 -> next cycle: alu_ctrl=0000, in1=7,
//     in2=FFFFFFFD, wr_idx=3, wr_en=1, ovf_en=1.
//  3. sra $4,$5,2 (rt=80000000, rs=1234) -> alu_ctrl=0110, in1=80000000,
//     alu_shamt=2.
//  4. Immediates with imm16=8000:
//     - andi -> in2=00008000, alu_ctrl=0010.
//     - addi -> in2=FFFF8000, ovf_en=1.
//     - slti -> alu_ctrl=1000.
//  5. Forwarding: fwd_a_sel=01 (exmem_res=AA), fwd_b_sel=10 (memwb_res=BB) on an
//     add -> in1=AA, in2=BB. Select 11 -> regfile values.
//  6. Pipeline control:
//     - stall for 3 cycles -> outputs frozen.
//     - flush+stall together -> bubble.
//     - opcode 3F -> illegal=1, wr_en=0.
//     - beq -> alu_ctrl=0001, is_branch=1.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU definitions: ALU control codes, opcode/funct constants and
// the forwarding-select encoding used by the ID/EX issue stage and the ALU.
package mips_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b0001,
    ALU_AND     = 4'b0010,
    ALU_OR      = 4'b0011,
    ALU_SLL     = 4'b0100,
    ALU_SRL     = 4'b0101,
    ALU_SRA     = 4'b0110,
    ALU_GREATER = 4'b0111,
    ALU_LESSER  = 4'b1000,
    ALU_NOR     = 4'b1001
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FWD_REGFILE     = 2'b00,
    FWD_EXMEM       = 2'b01,
    FWD_MEMWB       = 2'b10,
    FWD_REGFILE_ALT = 2'b11
  } fwd_sel_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

endpackage

// File: rtl/id_ex_alu_issue_if.sv
// ID/EX -> ALU interface: the registered issue bundle the ALU consumes.
interface id_ex_alu_issue_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  import mips_alu_pkg::*;

  logic          ex_valid;
  alu_ctrl_t     alu_ctrl;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [4:0]    alu_shamt;
  logic          ovf_en;
  logic          wr_en;
  logic [RW-1:0] wr_idx;
  logic          is_branch;
  logic          illegal;

  modport master (
    output ex_valid, alu_ctrl, alu_in1, alu_in2, alu_shamt,
           ovf_en, wr_en, wr_idx, is_branch, illegal
  );

  modport slave (
    input  ex_valid, alu_ctrl, alu_in1, alu_in2, alu_shamt,
           ovf_en, wr_en, wr_idx, is_branch, illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decoder producing the ALU control code and the
// operand-routing / writeback qualifiers for one instruction.
module alu_ctrl_decode
  import mips_alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_ctrl_t  alu_ctrl,
  output logic       ovf_en,
  output logic       wr_en,
  output logic       dst_is_rd,
  output logic       imm_sext,
  output logic       use_imm,
  output logic       is_shift,
  output logic       is_branch,
  output logic       illegal
);

  always_comb begin
    alu_ctrl  = ALU_ADD;
    ovf_en    = 1'b0;
    wr_en     = 1'b0;
    dst_is_rd = 1'b0;
    imm_sext  = 1'b1;
    use_imm   = 1'b0;
    is_shift  = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dst_is_rd = 1'b1;
        wr_en     = 1'b1;
        case (funct)
          F_ADD:  ovf_en = 1'b1;
          F_ADDU: ;
          F_SUB:  begin alu_ctrl = ALU_SUB; ovf_en = 1'b1; end
          F_SUBU: alu_ctrl = ALU_SUB;
          F_AND:  alu_ctrl = ALU_AND;
          F_OR:   alu_ctrl = ALU_OR;
          F_NOR:  alu_ctrl = ALU_NOR;
          F_SLT:  alu_ctrl = ALU_LESSER;
          F_SLL:  begin alu_ctrl = ALU_SLL; is_shift = 1'b1; end
          F_SRL:  begin alu_ctrl = ALU_SRL; is_shift = 1'b1; end
          F_SRA:  begin alu_ctrl = ALU_SRA; is_shift = 1'b1; end
          default: begin
            illegal = 1'b1;
            wr_en   = 1'b0;
          end
        endcase
      end
      OP_ADDI:  begin use_imm = 1'b1; wr_en = 1'b1; ovf_en = 1'b1; end
      OP_ADDIU: begin use_imm = 1'b1; wr_en = 1'b1; end
      OP_SLTI:  begin use_imm = 1'b1; wr_en = 1'b1; alu_ctrl = ALU_LESSER; end
      OP_ANDI:  begin use_imm = 1'b1; wr_en = 1'b1; alu_ctrl = ALU_AND; imm_sext = 1'b0; end
      OP_ORI:   begin use_imm = 1'b1; wr_en = 1'b1; alu_ctrl = ALU_OR;  imm_sext = 1'b0; end
      OP_LW:    begin use_imm = 1'b1; wr_en = 1'b1; end
      OP_SW:    use_imm = 1'b1;
      OP_BEQ,
      OP_BNE:   begin alu_ctrl = ALU_SUB; is_branch = 1'b1; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// Decode/issue stage: forwarding muxes, immediate extension and the ID/EX
// register that drives the ALU inputs.
module id_ex_alu_issue
  import mips_alu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic [4:0]    shamt_in,
  input  logic [RW-1:0] rt_idx,
  input  logic [RW-1:0] rd_idx,
  input  logic [15:0]   imm16,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [1:0]    fwd_a_sel,
  input  logic [1:0]    fwd_b_sel,
  input  logic [DW-1:0] exmem_res,
  input  logic [DW-1:0] memwb_res,
  input  logic          stall,
  input  logic          flush,
  id_ex_alu_issue_if.master ex
);

  alu_ctrl_t dec_ctrl;
  logic dec_ovf, dec_wr, dec_rd, dec_sext, dec_imm, dec_shift, dec_br, dec_ill;

  alu_ctrl_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .alu_ctrl  (dec_ctrl),
    .ovf_en    (dec_ovf),
    .wr_en     (dec_wr),
    .dst_is_rd (dec_rd),
    .imm_sext  (dec_sext),
    .use_imm   (dec_imm),
    .is_shift  (dec_shift),
    .is_branch (dec_br),
    .illegal   (dec_ill)
  );

  logic [DW-1:0] op_a, op_b, imm_ext;

  always_comb begin
    op_a = rs_data;
    case (fwd_sel_t'(fwd_a_sel))
      FWD_EXMEM: op_a = exmem_res;
      FWD_MEMWB: op_a = memwb_res;
      default:   ;
    endcase
    op_b = rt_data;
    case (fwd_sel_t'(fwd_b_sel))
      FWD_EXMEM: op_b = exmem_res;
      FWD_MEMWB: op_b = memwb_res;
      default:   ;
    endcase
    imm_ext = dec_sext ? {{(DW-16){imm16[15]}}, imm16} : {{(DW-16){1'b0}}, imm16};
  end

  // Next-state of the ID/EX slot; a flush or an empty ID slot loads a bubble.
  logic          bubble, load_en;
  logic          n_valid, n_ovf, n_wr, n_br, n_ill;
  alu_ctrl_t     n_ctrl;
  logic [DW-1:0] n_in1, n_in2;
  logic [4:0]    n_shamt;
  logic [RW-1:0] n_widx;

  always_comb begin
    bubble  = flush | ~id_valid;
    load_en = flush | ~stall;
    n_valid = 1'b0;
    n_ctrl  = ALU_ADD;
    n_in1   = '0;
    n_in2   = '0;
    n_shamt = '0;
    n_ovf   = 1'b0;
    n_wr    = 1'b0;
    n_widx  = '0;
    n_br    = 1'b0;
    n_ill   = 1'b0;
    if (!bubble) begin
      n_valid = 1'b1;
      n_ctrl  = dec_ctrl;
      n_in1   = dec_shift ? op_b : op_a;
      n_in2   = dec_imm ? imm_ext : op_b;
      n_shamt = dec_shift ? shamt_in : '0;
      n_ovf   = dec_ovf;
      n_wr    = dec_wr;
      n_widx  = dec_rd ? rd_idx : rt_idx;
      n_br    = dec_br;
      n_ill   = dec_ill;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex.ex_valid  <= 1'b0;
      ex.alu_ctrl  <= ALU_ADD;
      ex.alu_in1   <= '0;
      ex.alu_in2   <= '0;
      ex.alu_shamt <= '0;
      ex.ovf_en    <= 1'b0;
      ex.wr_en     <= 1'b0;
      ex.wr_idx    <= '0;
      ex.is_branch <= 1'b0;
      ex.illegal   <= 1'b0;
    end else if (load_en) begin
      ex.ex_valid  <= n_valid;
      ex.alu_ctrl  <= n_ctrl;
      ex.alu_in1   <= n_in1;
      ex.alu_in2   <= n_in2;
      ex.alu_shamt <= n_shamt;
      ex.ovf_en    <= n_ovf;
      ex.wr_en     <= n_wr;
      ex.wr_idx    <= n_widx;
      ex.is_branch <= n_br;
      ex.illegal   <= n_ill;
    end
  end

endmodule
